// File: rtl/chip8_scanout.sv
// chip8_scanout: raster-order 64x32 framebuffer reader, one pixel per handshake.
// Define CHIP8_SCANOUT_PREFETCH_EN to overlap the next byte read with shifting.
module chip8_scanout (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       frame_done,
  output logic       mem_rd,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_data,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic       pix_data,
  output logic [5:0] pix_x,
  output logic [4:0] pix_y,
  output logic       sof,
  output logic       eol,
  output logic       eof
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    SHIFT,
    DONE
  } state_t;

  state_t     state;
  logic [7:0] addr;
  logic [2:0] bitcnt;
  logic [7:0] shift;

`ifdef CHIP8_SCANOUT_PREFETCH_EN
  logic [7:0] hold;
  logic       hold_full;
  logic       rd_pend;
`endif

  logic [7:0] addr_nx;
  logic [7:0] shift_nx;
  logic [2:0] bit_nx;

  assign addr_nx  = addr + 8'd1;
  assign shift_nx = {shift[6:0], 1'b0};
  assign bit_nx   = bitcnt + 3'd1;

  // {pix_data, sof, eol, eof, pix_x, pix_y} for a given byte/bit position
  function automatic logic [14:0] tags(
    input logic [7:0] sh,
    input logic [7:0] ad,
    input logic [2:0] bc
  );
    tags = {sh[7],
            (ad == 8'd0) && (bc == 3'd0),
            (ad[2:0] == 3'd7) && (bc == 3'd7),
            (ad == 8'hff) && (bc == 3'd7),
            ad[2:0], bc, ad[7:3]};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      addr       <= '0;
      bitcnt     <= '0;
      shift      <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      pix_valid  <= 1'b0;
      {pix_data, sof, eol, eof, pix_x, pix_y} <= '0;
`ifdef CHIP8_SCANOUT_PREFETCH_EN
      hold       <= '0;
      hold_full  <= 1'b0;
      rd_pend    <= 1'b0;
`endif
    end else begin
      mem_rd     <= 1'b0;
      frame_done <= 1'b0;
`ifdef CHIP8_SCANOUT_PREFETCH_EN
      rd_pend <= mem_rd && (state == SHIFT);
      if (rd_pend) begin
        hold      <= mem_data;
        hold_full <= 1'b1;
      end
`endif
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= FETCH;
            busy     <= 1'b1;
            mem_rd   <= 1'b1;
            mem_addr <= '0;
            addr     <= '0;
            bitcnt   <= '0;
          end
        end
        FETCH: state <= WAIT;
        WAIT: begin
          state     <= SHIFT;
          shift     <= mem_data;
          bitcnt    <= '0;
          pix_valid <= 1'b1;
          {pix_data, sof, eol, eof, pix_x, pix_y} <=
            tags(mem_data, addr, 3'd0);
`ifdef CHIP8_SCANOUT_PREFETCH_EN
          mem_rd   <= (addr != 8'hff);
          mem_addr <= addr_nx;
`endif
        end
        SHIFT: begin
          if (pix_ready) begin
            if (bitcnt != 3'd7) begin
              shift  <= shift_nx;
              bitcnt <= bit_nx;
              {pix_data, sof, eol, eof, pix_x, pix_y} <=
                tags(shift_nx, addr, bit_nx);
            end else if (addr == 8'hff) begin
              state      <= DONE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              pix_valid  <= 1'b0;
              {pix_data, sof, eol, eof, pix_x, pix_y} <= '0;
            end else begin
              addr   <= addr_nx;
              bitcnt <= '0;
`ifdef CHIP8_SCANOUT_PREFETCH_EN
              if (hold_full) begin
                shift     <= hold;
                hold_full <= 1'b0;
                mem_rd    <= (addr_nx != 8'hff);
                mem_addr  <= addr_nx + 8'd1;
                {pix_data, sof, eol, eof, pix_x, pix_y} <=
                  tags(hold, addr_nx, 3'd0);
              end else begin
                state     <= FETCH;
                pix_valid <= 1'b0;
                mem_rd    <= 1'b1;
                mem_addr  <= addr_nx;
                {pix_data, sof, eol, eof, pix_x, pix_y} <= '0;
              end
`else
              state     <= FETCH;
              pix_valid <= 1'b0;
              mem_rd    <= 1'b1;
              mem_addr  <= addr_nx;
              {pix_data, sof, eol, eof, pix_x, pix_y} <= '0;
`endif
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chip8_scanout.sv
// tb_chip8_scanout: directed frames against a framebuffer model,
// pixels checked through an expected-pixel queue.
module tb_chip8_scanout;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       pix_ready = 1'b0;
  logic       busy, frame_done, mem_rd;
  logic       pix_valid, pix_data, sof, eol, eof;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic [5:0] pix_x;
  logic [4:0] pix_y;

  logic [7:0]  fb [256];
  logic [14:0] q [$];
  logic [14:0] mon_e;
  logic [7:0]  stall_s;

  int n_cmp = 0;
  int n_bad = 0;
  int hs_cnt = 0;
  int eol_cnt = 0;
  int rd_cnt = 0;
  int fd_cnt = 0;
  int rmode = 0;
  int k;

`ifdef CHIP8_SCANOUT_PREFETCH_EN
  localparam int EXP_DONE = 2051;
`else
  localparam int EXP_DONE = 2561;
`endif

  always #5 clk = ~clk;

  chip8_scanout dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .frame_done (frame_done),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .sof        (sof),
    .eol        (eol),
    .eof        (eof)
  );

  // synchronous read port; garbage when not reading
  always @(posedge clk)
    mem_data <= mem_rd ? fb[mem_addr] : 8'($urandom);

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] exp_tag(input int k);
    logic [7:0] a;
    logic [2:0] b;
    logic [5:0] x;
    a = 8'(k >> 3);
    b = 3'(k);
    x = {a[2:0], b};
    return {a[7:3], x, fb[a][3'd7 - b], k == 0, x == 6'd63, k == 2047};
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_rd) rd_cnt++;
      if (frame_done) fd_cnt++;
      if (pix_valid && pix_ready) begin
        hs_cnt++;
        if (eol) eol_cnt++;
        chk("pix_unexpected", 32'(q.size() == 0), 0);
        if (q.size() != 0) begin
          mon_e = q.pop_front();
          chk("pix", {pix_y, pix_x, pix_data, sof, eol, eof}, mon_e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    case (rmode)
      0:       pix_ready = 1'b1;
      1:       pix_ready = ($urandom_range(0, 1) == 1);
      default: pix_ready = 1'b0;
    endcase
  endtask

  task automatic push_frame();
    q.delete();
    for (int i = 0; i < 2048; i++) q.push_back(exp_tag(i));
    hs_cnt  = 0;
    eol_cnt = 0;
    rd_cnt  = 0;
  endtask

  task automatic begin_frame(input bit hold);
    tick();
    start = 1'b1;
    push_frame();
    fd_cnt = 0;
    tick();
    if (!hold) start = 1'b0;
    chk("n1_busy", busy, 1);
    chk("n1_rd", mem_rd, 1);
    chk("n1_addr", mem_addr, 0);
    tick();
    chk("n2_valid", pix_valid, 0);
    tick();
    chk("n3_valid", pix_valid, 1);
    chk("n3_sof", sof, 1);
    chk("n3_xy", {pix_y, pix_x}, 0);
    chk("n3_data", pix_data, fb[0][7]);
  endtask

  task automatic finish_frame(input int n0, input int exp_n);
    int n;
    n = n0;
    while (!frame_done && n < 20000) begin
      tick();
      n++;
    end
    chk("done_seen", frame_done, 1);
    if (exp_n != 0) chk("done_cycle", n, exp_n);
    chk("busy_at_done", busy, 0);
    chk("hs_count", hs_cnt, 2048);
    chk("eol_count", eol_cnt, 32);
    chk("rd_count", rd_cnt, 256);
    chk("q_left", q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) fb[i] = 8'h00;
    fb[0] = 8'h80;

    repeat (3) tick();
    chk("reset_outs", {busy, frame_done, mem_rd, mem_addr, pix_valid,
                       pix_data, pix_x, pix_y, sof, eol, eof}, 0);
    reset = 1'b0;

    // single lit pixel at (0,0)
    begin_frame(1'b0);
    finish_frame(3, EXP_DONE);

    // lit pixel at (63,31) and a pattern on row 1
    fb[255] = 8'h01;
    fb[9]   = 8'hA5;
    begin_frame(1'b0);
    finish_frame(3, EXP_DONE);

    // 5-cycle stall on pixel (3,0)
    fb[0] = 8'h90;
    begin_frame(1'b0);
    k = 0;
    while (!(pix_valid && pix_x == 6'd3 && pix_y == 5'd0) && k < 20) begin
      tick();
      k++;
    end
    chk("stall_find_x", pix_x, 3);
    chk("stall_data", pix_data, 1);
    pix_ready = 1'b0;
    rmode = 2;
    stall_s = {pix_valid, pix_data, pix_x};
    repeat (5) begin
      tick();
      chk("stall_hold", {pix_valid, pix_data, pix_x}, stall_s);
    end
    rmode = 0;
    pix_ready = 1'b1;
    finish_frame(8 + k, EXP_DONE + 5);

    // start pulse while busy is ignored
    begin_frame(1'b0);
    k = 0;
    while (hs_cnt < 100 && k < 500) begin
      tick();
      k++;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    finish_frame(4 + k, EXP_DONE);
    repeat (5) tick();
    chk("busy_start_fd", fd_cnt, 1);
    chk("busy_start_idle", busy, 0);
    chk("busy_start_rd", rd_cnt, 256);

    // start held high: back-to-back frames
    begin_frame(1'b1);
    finish_frame(3, EXP_DONE);
    push_frame();
    k = 0;
    while (!mem_rd && k < 3) begin
      tick();
      k++;
    end
    chk("held_restart", (k >= 1 && k <= 2 && mem_rd), 1);
    chk("held_addr", mem_addr, 0);
    start = 1'b0;
    finish_frame(1, EXP_DONE);

    // reset one cycle after the read of byte 40
    begin_frame(1'b0);
    k = 0;
    while (!(mem_rd && mem_addr == 8'd40) && k < 1000) begin
      tick();
      k++;
    end
    chk("rd40_found", {mem_rd, mem_addr}, {1'b1, 8'd40});
    tick();
    reset = 1'b1;
    tick();
    chk("midrst_outs", {busy, frame_done, mem_rd, mem_addr, pix_valid,
                        pix_data, pix_x, pix_y, sof, eol, eof}, 0);
    reset = 1'b0;
    q.delete();
    hs_cnt = 0;
    fd_cnt = 0;
    repeat (20) tick();
    chk("midrst_no_pix", hs_cnt, 0);
    chk("midrst_no_done", fd_cnt, 0);

    // random backpressure
    rmode = 1;
    begin_frame(1'b0);
    finish_frame(3, 0);
    rmode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
